// File: rtl/store64_ser.sv
// store64_ser: serializes a 64-bit Keccak lane into bytes, LSB first.
// Inverse of the little-endian lane load. Bytes leave on a valid/ready
// stream; a new lane can be accepted on the last-byte handshake, so lanes
// stream back-to-back without a bubble.
// Optional feature macro: STORE64_PARTIAL_EN adds i_nbyte (byte count - 1)
// so a short final lane can be emitted when squeezing SHAKE output.
// Without it every lane is 8 bytes.
module store64_ser #(
  parameter int BW_DATA = 64
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [7:0]         o_byte,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last
`ifdef STORE64_PARTIAL_EN
  ,
  input  logic [2:0]         i_nbyte
`endif
);

  localparam int NB = BW_DATA / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [BW_DATA-1:0] shift_reg, shift_next;
  logic [2:0]         cnt_reg, cnt_next;
  logic [BW_DATA-1:0] shifted;
  logic [2:0]         lane_cnt_init;
  logic               out_hs;
  logic               in_hs;

  // Byte-wise right shift by one byte; the top byte fills with zero.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_shift
      if (gi < NB - 1) begin : g_mid
        assign shifted[8*gi +: 8] = shift_reg[8*(gi+1) +: 8];
      end else begin : g_top
        assign shifted[8*gi +: 8] = 8'h00;
      end
    end
  endgenerate

  // Number of bytes minus one for the lane being accepted.
`ifdef STORE64_PARTIAL_EN
  assign lane_cnt_init = i_nbyte;
`else
  assign lane_cnt_init = 3'd7;
`endif

  // State, shift register and byte counter; cleared by the active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Handshakes, stream outputs and next-state selection.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;

    o_valid = (state_reg == SHIFT);
    o_byte  = shift_reg[7:0];
    o_last  = o_valid && (cnt_reg == 3'd0);
    out_hs  = o_valid && i_ready;
    // Ready while empty, or while the final byte is leaving this cycle.
    o_ready = !o_valid || (out_hs && o_last);
    in_hs   = i_valid && o_ready;

    if (in_hs) begin
      // A new lane wins over the return to IDLE on the last-byte handshake.
      shift_next = i_data;
      cnt_next   = lane_cnt_init;
      state_next = SHIFT;
    end else if (out_hs) begin
      if (o_last) begin
        state_next = IDLE;
      end else begin
        shift_next = shifted;
        cnt_next   = cnt_reg - 3'd1;
      end
    end
  end

endmodule
